// File: rtl/perf_counter_ctrl_if.sv
// perf_counter_ctrl_if: word-offset MMIO bus between core decode and the perf counter controller
interface perf_counter_ctrl_if #(parameter int ADDR_W = 3);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       wdata;
  logic              re;
  logic [31:0]       rdata;
  logic              rvalid;
  modport master (output addr, we, wdata, re, input rdata, rvalid);
  modport slave (input addr, we, wdata, re, output rdata, rvalid);
endinterface

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: MMIO controller for the cycle/instr counter pair; define PERF_IRQ_EN to add perf_irq
module perf_counter_ctrl #(
  parameter int          ADDR_W  = 3,
  parameter logic [31:0] WIN_RST = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_stall,
  input  logic [31:0]        live_instr,
  input  logic [31:0]        live_cycle,
  output logic               cnt_reset,
  output logic               cnt_stall,
`ifdef PERF_IRQ_EN
  output logic               perf_irq,
`endif
  perf_counter_ctrl_if.slave mmio
);
  localparam logic [1:0] RUN = 2'd0, CLR = 2'd1, MEAS = 2'd2, HELD = 2'd3;
  logic [1:0]  state, state_nx;
  logic [31:0] window, snap_cycle, snap_instr, prev_cycle, prev_instr, rd_mux;
  logic        ovf_cycle, ovf_instr, win_done, prev_rst;
  logic        ctrl_wr, arm, clr, frz, unf, win_hit, snap, done_set, unf_hit, reset_nx, ovf_clr;
  logic        wrap_cycle, wrap_instr;
  assign cnt_stall = core_stall;
  // ARM outranks every other CTRL bit even when it is itself ignored for WINDOW==0
  assign ctrl_wr = mmio.we && mmio.addr == ADDR_W'(0);
  assign arm = ctrl_wr && mmio.wdata[3] && window != 32'd0 && state != CLR;
  assign clr = ctrl_wr && !mmio.wdata[3] && mmio.wdata[0];
  assign frz = ctrl_wr && !mmio.wdata[3] && !mmio.wdata[0] && mmio.wdata[1];
  assign unf = ctrl_wr && mmio.wdata[3:0] == 4'b0100;
  assign win_hit = state == MEAS && live_cycle == window;
  assign wrap_cycle = prev_cycle[31] && !live_cycle[31] && !prev_rst;
  assign wrap_instr = prev_instr[31] && !live_instr[31] && !prev_rst;
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_nx;
  always_comb
    state_nx = arm ? CLR :
               state == CLR ? MEAS :
               win_hit || (frz && (state == RUN || state == MEAS)) ? HELD :
               unf && state == HELD ? RUN : state;
  always_comb begin
    snap = state_nx == HELD && state != HELD;
    done_set = win_hit && !arm;
    unf_hit = unf && state == HELD;
    reset_nx = clr || state_nx == CLR;
    ovf_clr = clr || arm;
  end
  always_comb
    rd_mux = mmio.addr == ADDR_W'(1) ? {27'd0, win_done, ovf_instr, ovf_cycle, state} :
             mmio.addr == ADDR_W'(2) ? (state == HELD ? snap_cycle : live_cycle) :
             mmio.addr == ADDR_W'(3) ? (state == HELD ? snap_instr : live_instr) :
             mmio.addr == ADDR_W'(4) ? window : 32'd0;
  always_ff @(posedge clk)
    if (rst) begin
      window <= WIN_RST;
      snap_cycle <= 32'd0;
      snap_instr <= 32'd0;
      prev_cycle <= 32'd0;
      prev_instr <= 32'd0;
      prev_rst <= 1'b0;
      cnt_reset <= 1'b0;
      ovf_cycle <= 1'b0;
      ovf_instr <= 1'b0;
      win_done <= 1'b0;
      mmio.rvalid <= 1'b0;
      mmio.rdata <= 32'd0;
    end else begin
      if (mmio.we && mmio.addr == ADDR_W'(4)) window <= mmio.wdata;
      if (snap) snap_cycle <= live_cycle;
      if (snap) snap_instr <= live_instr;
      prev_cycle <= live_cycle;
      prev_instr <= live_instr;
      prev_rst <= cnt_reset;
      cnt_reset <= reset_nx;
      ovf_cycle <= !ovf_clr && (ovf_cycle || wrap_cycle);
      ovf_instr <= !ovf_clr && (ovf_instr || wrap_instr);
      win_done <= done_set || (win_done && !unf_hit && !arm);
      mmio.rvalid <= mmio.re;
      mmio.rdata <= mmio.re ? rd_mux : 32'd0;
    end
`ifdef PERF_IRQ_EN
  logic stat_rd;
  assign stat_rd = mmio.re && mmio.addr == ADDR_W'(1);
  always_ff @(posedge clk)
    if (rst) perf_irq <= 1'b0;
    else perf_irq <= done_set || (perf_irq && !stat_rd && !unf_hit && !arm);
`endif
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb_perf_counter_ctrl: directed + randomized bench with a behavioural counter and window expectations
module tb_perf_counter_ctrl;
  logic        clk = 1'b0, rst = 1'b1, core_stall = 1'b0;
  logic [31:0] live_instr = 32'd0, live_cycle = 32'd0;
  logic        cnt_reset, cnt_stall;
  logic        auto_cnt = 1'b0;
  int          n_chk = 0, n_err = 0;
  perf_counter_ctrl_if #(.ADDR_W(3)) mmio();
`ifdef PERF_IRQ_EN
  logic        perf_irq;
`endif
  perf_counter_ctrl #(.ADDR_W(3), .WIN_RST(32'd0)) dut (
    .clk(clk), .rst(rst), .core_stall(core_stall), .live_instr(live_instr), .live_cycle(live_cycle),
    .cnt_reset(cnt_reset), .cnt_stall(cnt_stall),
`ifdef PERF_IRQ_EN
    .perf_irq(perf_irq),
`endif
    .mmio(mmio));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Counter block model: cycle counts every clock, instr counts unstalled clocks, both zero on reset_counters
  task automatic tick();
    logic r, s;
    r = cnt_reset;
    s = core_stall;
    @(posedge clk);
    #1;
    if (auto_cnt) begin
      live_cycle = r ? 32'd0 : live_cycle + 32'd1;
      live_instr = r ? 32'd0 : live_instr + {31'd0, !s};
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    mmio.addr = 3'(a);
    mmio.wdata = d;
    mmio.we = 1'b1;
    tick();
    mmio.we = 1'b0;
  endtask
  task automatic rdc(input string tag, input int a, input logic [31:0] exp);
    mmio.addr = 3'(a);
    mmio.re = 1'b1;
    tick();
    mmio.re = 1'b0;
    chk({tag, "_rvalid"}, 32'(mmio.rvalid), 32'd1);
    chk(tag, mmio.rdata, exp);
  endtask
  // Lets the window run; expects HELD with the live values seen in the cycle live_cycle matched WINDOW
  task automatic run_window(input string tag, input logic [31:0] w, input bit rnd_stall);
    logic [31:0] ei;
    int k;
    k = 0;
    while (live_cycle != w && k < 5000) begin
      core_stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 5000), 32'd1);
    ei = live_instr;
    core_stall = 1'b0;
    tick();
`ifdef PERF_IRQ_EN
    chk({tag, "_irq_set"}, 32'(perf_irq), 32'd1);
`endif
    rdc({tag, "_status"}, 1, 32'h13);
`ifdef PERF_IRQ_EN
    chk({tag, "_irq_clr"}, 32'(perf_irq), 32'd0);
`endif
    rdc({tag, "_snap_cyc"}, 2, w);
    ticks($urandom_range(2, 8));
    rdc({tag, "_snap_cyc_hold"}, 2, w);
    rdc({tag, "_snap_ins"}, 3, ei);
    rdc({tag, "_status_hold"}, 1, 32'h13);
  endtask
  initial begin
    logic [31:0] v;
    mmio.addr = 3'd0;
    mmio.we = 1'b0;
    mmio.re = 1'b0;
    mmio.wdata = 32'd0;
    ticks(3);
    rst = 1'b0;
    chk("rst_cnt_reset", 32'(cnt_reset), 32'd0);
    chk("rst_rvalid", 32'(mmio.rvalid), 32'd0);
    chk("rst_rdata", mmio.rdata, 32'd0);
`ifdef PERF_IRQ_EN
    chk("rst_irq", 32'(perf_irq), 32'd0);
`endif
    auto_cnt = 1'b1;
    rdc("rst_status", 1, 32'd0);
    tick();
    chk("rvalid_drop", 32'(mmio.rvalid), 32'd0);
    chk("rdata_idle", mmio.rdata, 32'd0);
    rdc("rst_window", 4, 32'd0);
    core_stall = 1'b1;
    #1 chk("stall_pass_1", 32'(cnt_stall), 32'd1);
    core_stall = 1'b0;
    #1 chk("stall_pass_0", 32'(cnt_stall), 32'd0);
    ticks($urandom_range(3, 20));
    wr(0, 32'd1);
    chk("clr_pulse", 32'(cnt_reset), 32'd1);
    tick();
    chk("clr_pulse_end", 32'(cnt_reset), 32'd0);
    rdc("cyc_after_clr", 2, 32'd0);
    wr(4, 32'd100);
    rdc("win_rd", 4, 32'd100);
    wr(0, 32'd8);
    chk("arm_pulse", 32'(cnt_reset), 32'd1);
    rdc("st_clear", 1, 32'd1);
    chk("arm_pulse_end", 32'(cnt_reset), 32'd0);
    rdc("st_measure", 1, 32'd2);
    run_window("w100", 32'd100, 1'b0);
    wr(0, 32'd4);
    rdc("unf_status", 1, 32'd0);
    rdc("unf_live_cyc", 2, live_cycle);
    rdc("unf_live_ins", 3, live_instr);
    auto_cnt = 1'b0;
    live_cycle = 32'd500;
    v = $urandom_range(0, 32'h7fff_ffff);
    live_instr = v;
    wr(0, 32'd2);
    live_cycle = 32'd777;
    live_instr = 32'd3;
    rdc("frz_cyc", 2, 32'd500);
    rdc("frz_ins", 3, v);
    rdc("frz_status", 1, 32'd3);
    wr(0, 32'd4);
    rdc("thaw_status", 1, 32'd0);
    rdc("thaw_cyc", 2, 32'd777);
    rdc("thaw_ins", 3, 32'd3);
    live_instr = 32'hFFFF_FFFF;
    tick();
    live_instr = 32'd0;
    tick();
    rdc("ovf_instr", 1, 32'h08);
    ticks(4);
    rdc("ovf_instr_sticky", 1, 32'h08);
    live_cycle = 32'hFFFF_FFF0;
    tick();
    live_cycle = 32'd5;
    tick();
    rdc("ovf_both", 1, 32'h0C);
    wr(0, 32'd1);
    rdc("ovf_cleared", 1, 32'd0);
    live_instr = 32'hFFFF_FFFF;
    live_cycle = 32'hFFFF_FFFF;
    ticks(2);
    wr(0, 32'd1);
    tick();
    live_instr = 32'd0;
    live_cycle = 32'd0;
    tick();
    rdc("no_ovf_after_clr", 1, 32'd0);
    auto_cnt = 1'b1;
    wr(4, 32'd0);
    wr(0, 32'hB);
    chk("armz_no_pulse", 32'(cnt_reset), 32'd0);
    rdc("armz_status", 1, 32'd0);
    wr(4, 32'd5);
    wr(0, 32'hB);
    chk("arm5_pulse", 32'(cnt_reset), 32'd1);
    rdc("arm5_clear", 1, 32'd1);
    rdc("arm5_measure", 1, 32'd2);
    run_window("w5", 32'd5, 1'b1);
    wr(6, 32'hDEAD_BEEF);
    rdc("undef_rd", 6, 32'd0);
    rdc("ctrl_rd", 0, 32'd0);
    mmio.addr = 3'd4;
    mmio.wdata = 32'h1234;
    mmio.we = 1'b1;
    mmio.re = 1'b1;
    tick();
    mmio.we = 1'b0;
    mmio.re = 1'b0;
    chk("rw_pre_value", mmio.rdata, 32'd5);
    rdc("rw_post_value", 4, 32'h1234);
    for (int n = 0; n < 5; n++) begin
      v = $urandom_range(10, 200);
      wr(4, v);
      wr(0, 32'd8);
      chk("rnd_arm_pulse", 32'(cnt_reset), 32'd1);
      ticks(2);
      run_window("rnd", v, 1'b1);
    end
    wr(4, 32'd150);
    wr(0, 32'd8);
    ticks(6);
    wr(0, 32'd8);
    chk("rearm_pulse", 32'(cnt_reset), 32'd1);
    rdc("rearm_clear", 1, 32'd1);
    rdc("rearm_measure", 1, 32'd2);
    run_window("rearm", 32'd150, 1'b1);
    wr(4, 32'd50);
    wr(0, 32'd8);
    ticks(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_cnt_reset", 32'(cnt_reset), 32'd0);
    rdc("rst_mid_status", 1, 32'd0);
    rdc("rst_mid_cyc", 2, live_cycle);
    rdc("rst_mid_window", 4, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/perf_counter_ctrl.md
Name: perf_counter_ctrl

Overview:
- MMIO-mapped controller for the core's retired-instruction and cycle counter pair.
- Drives the counter's `reset_counters` and `stall_detected` inputs, and reads back `instr_counter` and `cycle_counter`.
- Supports clear, freeze/unfreeze with snapshot, fixed-length measurement windows and sticky wrap flags.
- Sits between the core's MMIO decode (local word offset only) and the counter block.

Parameters:
- ADDR_W, 3, width of the local word offset.
- WIN_RST, 32'd0, reset value of the WINDOW register.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- core_stall  in  1  core pipeline stall, forwarded to counter
- live_instr  in  32  `instr_counter` from counter block
- live_cycle  in  32  `cycle_counter` from counter block
- cnt_reset  out  1  to counter `reset_counters`
- cnt_stall  out  1  to counter `stall_detected`
- mmio_addr  in  ADDR_W  word offset
- mmio_we  in  1  write strobe
- mmio_wdata  in  32  write data
- mmio_re  in  1  read strobe
- mmio_rdata  out  32  read data
- mmio_rvalid  out  1  read data valid

Behaviour:
- Register map, word offsets:
  - 0 CTRL (W): bit0 CLEAR, bit1 FREEZE, bit2 UNFREEZE, bit3 ARM. All bits self-clearing; CTRL reads 0.
  - 1 STATUS (R): [1:0] state, [2] ovf_cycle, [3] ovf_instr, [4] win_done.
  - 2 CYCLE (R).
  - 3 INSTR (R).
  - 4 WINDOW (R/W).
  - Writes to undefined offsets are ignored; reads of them return 0.
- Multiple CTRL bits in one write: only the highest-priority set bit acts. Priority: ARM > CLEAR > FREEZE > UNFREEZE.
- States: RUN=0, CLEAR=1, MEASURE=2, HELD=3.
- Transitions:
  - RUN, ARM with WINDOW!=0 -> CLEAR.
  - CLEAR -> MEASURE, unconditionally after 1 cycle.
  - MEASURE, live_cycle == WINDOW -> HELD. On that edge: snap_cycle <= live_cycle, snap_instr <= live_instr, win_done <= 1.
  - RUN or MEASURE, FREEZE -> HELD. Snapshot live values on the edge the write is captured.
  - HELD, UNFREEZE -> RUN. Clears win_done.
  - Any state, ARM with WINDOW==0: ignored.
  - MEASURE or HELD, ARM -> CLEAR (restart).
- CLEAR command: cnt_reset=1 for exactly one cycle, the cycle after the write. State unchanged. ovf_cycle and ovf_instr are cleared.
- Entering the CLEAR state also drives cnt_reset=1 for that cycle.
- cnt_reset is registered and is 0 otherwise.
- cnt_stall = core_stall, combinational pass-through. The controller never gates it.
- Wrap detection, per counter:
  - Register the previous value and the previous cnt_reset.
  - Set the sticky ovf bit when prev[31]=1, curr[31]=0 and prev cnt_reset=0.
  - ovf bits are cleared only by CLEAR, ARM or rst.
- Reads:
  - mmio_rvalid asserts exactly 1 cycle after mmio_re, for one cycle.
  - mmio_rdata is held for that cycle and is 0 when rvalid=0.
  - CYCLE/INSTR return the snapshot in HELD and the live value otherwise, sampled in the mmio_re cycle.
- Simultaneous read and write in the same cycle: both are serviced; the read returns the pre-write value.
- WINDOW write while in MEASURE: takes effect immediately. If live_cycle already exceeds the new value, the window completes only after the 32-bit counter wraps.
- Reset values: state=RUN, WINDOW=WIN_RST, snapshots=0, ovf/win_done=0, cnt_reset=0, mmio_rvalid=0, mmio_rdata=0.
- rst mid-MEASURE returns to RUN with no snapshot taken.

Optional Feature:
- PERF_IRQ_EN defined:
  - Adds output port `perf_irq`, width 1, registered.
  - perf_irq rises on the same edge win_done sets.
  - It clears on a STATUS read (effective the cycle after mmio_re), UNFREEZE, ARM or rst. win_done itself is unaffected by a STATUS read.
- PERF_IRQ_EN undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then read STATUS -> rvalid one cycle later, rdata=0. Write CTRL=1 -> cnt_reset high for exactly 1 cycle, then live counters restart from 0.
- WINDOW=100, CTRL=8, core_stall low -> state CLEAR then MEASURE. Entry into HELD with snap_cycle=100, snap_instr=100, win_done=1. CYCLE reads stay 100 while live counting continues.
- In RUN, write CTRL=2 with live_cycle=500 -> HELD, CYCLE reads 500. Write CTRL=4 -> RUN, subsequent reads return live values.
- Drive live_instr 0xFFFFFFFF then 0 without cnt_reset -> ovf_instr=1, sticky. CTRL=1 -> ovf_instr=0. The 0 following a controller clear does not set ovf.
- Write CTRL=0xB (ARM+CLEAR+FREEZE) with WINDOW=0 -> no state change and no cnt_reset pulse. Same write with WINDOW=5 -> CLEAR entered; FREEZE and CLEAR are ignored.
- With PERF_IRQ_EN: window completes -> perf_irq=1. Read STATUS -> rdata[4]=1, perf_irq=0 the next cycle.
